reset_sequencer_arty7: RTL



---
 rtl/reset_seq_pkg.sv | 43 ++++
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/reset_sequencer_arty7.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the Arty7 reset sequencer: FSM states, reset causes
// and the reset-event priority ordering.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_HOLD    = 2'd0,
    SEQ_STRETCH = 2'd1,
    SEQ_PERIPH  = 2'd2,
    SEQ_RUN     = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_LOCK = 2'b01,
    CAUSE_BTN  = 2'b10,
    CAUSE_SW   = 2'b11
  } rst_cause_e;

  typedef struct packed {
    logic       hit;
    rst_cause_e cause;
  } rst_event_t;

  // Highest-priority pending reset event: lock loss, then button, then software.
  function automatic rst_event_t pick_event(input logic lock_ok,
                                            input logic btn_ok,
                                            input logic sw_req);
    rst_event_t ev;
    ev.hit   = 1'b1;
    ev.cause = CAUSE_POR;
    if (!lock_ok) begin
      ev.cause = CAUSE_LOCK;
    end else if (!btn_ok) begin
      ev.cause = CAUSE_BTN;
    end else if (sw_req) begin
      ev.cause = CAUSE_SW;
    end else begin
      ev.hit = 1'b0;
    end
    return ev;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with configurable depth and reset value.
module cdc_sync_bit #(
  parameter int unsigned Depth    = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic RESETn_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      sync_q <= {Depth{ResetVal}};
    end else begin
      sync_q <= {sync_q[Depth-2:0], d_i};
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/reset_sequencer_arty7.sv
// Staged reset sequencer behind the Arty7 MMCM: synchronizes lock and the
// pushbutton, debounces the button, then releases the peripheral reset
// followed by the CPU reset. Outputs assert asynchronously via RESETn_i and
// otherwise change only on clk_i.
module reset_sequencer_arty7
  import reset_seq_pkg::*;
#(
  parameter int unsigned SyncStages        = 2,
  parameter int unsigned DebounceCycles    = 1024,
  parameter int unsigned LockStretchCycles = 256,
  parameter int unsigned PeriphToCpuCycles = 16
) (
  input  logic       clk_i,
  input  logic       RESETn_i,
  input  logic       mmcm_locked_i,
  input  logic       btn_rstn_i,
  input  logic       sw_rst_req_i,
  output logic       periph_rstn_o,
  output logic       cpu_rstn_o,
  output logic [1:0] rst_cause_o,
  output logic       seq_busy_o
);

  localparam int unsigned DbCntW  = $clog2(DebounceCycles + 1);
  localparam int unsigned SeqMax  = (LockStretchCycles > PeriphToCpuCycles) ?
                                    LockStretchCycles : PeriphToCpuCycles;
  localparam int unsigned SeqCntW = $clog2(SeqMax + 1);

  localparam logic [1:0] ST_HOLD    = SEQ_HOLD;
  localparam logic [1:0] ST_STRETCH = SEQ_STRETCH;
  localparam logic [1:0] ST_PERIPH  = SEQ_PERIPH;
  localparam logic [1:0] ST_RUN     = SEQ_RUN;

  logic               lock_s;
  logic               btn_s;
  logic               btn_db;
  logic [DbCntW-1:0]  db_cnt_q;

  logic [1:0]         state_q,  state_nxt;
  logic [SeqCntW-1:0] seq_cnt_q, seq_cnt_nxt;
  logic               periph_nxt;
  logic               cpu_nxt;
  logic [1:0]         cause_nxt;
  rst_event_t         ev;

  cdc_sync_bit #(
    .Depth    (SyncStages),
    .ResetVal (1'b0)
  ) u_sync_lock (
    .clk_i    (clk_i),
    .RESETn_i (RESETn_i),
    .d_i      (mmcm_locked_i),
    .q_o      (lock_s)
  );

  cdc_sync_bit #(
    .Depth    (SyncStages),
    .ResetVal (1'b1)
  ) u_sync_btn (
    .clk_i    (clk_i),
    .RESETn_i (RESETn_i),
    .d_i      (btn_rstn_i),
    .q_o      (btn_s)
  );

  // Accept a new button level only after it has held for DebounceCycles cycles.
  always_ff @(posedge clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      btn_db   <= 1'b1;
      db_cnt_q <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbCntW'(DebounceCycles - 1)) begin
      btn_db   <= btn_s;
      db_cnt_q <= '0;
    end else if (db_cnt_q != DbCntW'(DebounceCycles)) begin
      db_cnt_q <= db_cnt_q + DbCntW'(1);
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      state_q       <= ST_HOLD;
      seq_cnt_q     <= '0;
      periph_rstn_o <= 1'b0;
      cpu_rstn_o    <= 1'b0;
      seq_busy_o    <= 1'b1;
      rst_cause_o   <= CAUSE_POR;
    end else begin
      state_q       <= state_nxt;
      seq_cnt_q     <= seq_cnt_nxt;
      periph_rstn_o <= periph_nxt;
      cpu_rstn_o    <= cpu_nxt;
      seq_busy_o    <= ~cpu_nxt;
      rst_cause_o   <= cause_nxt;
    end
  end

  // Next-state logic: reset events preempt the staged release from any
  // non-HOLD state; software requests count only once the CPU is running.
  always_comb begin
    state_nxt   = state_q;
    seq_cnt_nxt = seq_cnt_q;
    periph_nxt  = periph_rstn_o;
    cpu_nxt     = cpu_rstn_o;
    cause_nxt   = rst_cause_o;
    ev          = pick_event(lock_s, btn_db, sw_rst_req_i && (state_q == ST_RUN));

    if ((state_q != ST_HOLD) && ev.hit) begin
      state_nxt   = ST_HOLD;
      seq_cnt_nxt = '0;
      periph_nxt  = 1'b0;
      cpu_nxt     = 1'b0;
      cause_nxt   = ev.cause;
    end else begin
      case (state_q)
        ST_HOLD: begin
          seq_cnt_nxt = '0;
          periph_nxt  = 1'b0;
          cpu_nxt     = 1'b0;
          if (lock_s && btn_db) begin
            state_nxt = ST_STRETCH;
          end
        end
        ST_STRETCH: begin
          if (seq_cnt_q == SeqCntW'(LockStretchCycles - 1)) begin
            state_nxt   = ST_PERIPH;
            seq_cnt_nxt = '0;
            periph_nxt  = 1'b1;
          end else if (seq_cnt_q != SeqCntW'(SeqMax)) begin
            seq_cnt_nxt = seq_cnt_q + SeqCntW'(1);
          end
        end
        ST_PERIPH: begin
          if (seq_cnt_q == SeqCntW'(PeriphToCpuCycles - 1)) begin
            state_nxt   = ST_RUN;
            seq_cnt_nxt = '0;
            cpu_nxt     = 1'b1;
          end else if (seq_cnt_q != SeqCntW'(SeqMax)) begin
            seq_cnt_nxt = seq_cnt_q + SeqCntW'(1);
          end
        end
        ST_RUN: begin
          seq_cnt_nxt = '0;
        end
        default: begin
          state_nxt   = ST_HOLD;
          seq_cnt_nxt = '0;
          periph_nxt  = 1'b0;
          cpu_nxt     = 1'b0;
        end
      endcase
    end
  end

endmodule
